tiny_count_monitor: RTL

Receive-side companion to the 4-bit up/down counter. It samples the counter value `cnt_in` every cycle and recovers what the counter did: step, direction and enable activity. It checks that every change is a legal ±1 move (mod 2^WIDTH), locks after a run of legal steps, counts errors and keeps a net-position accumulator. It sits in the verification/self-test path, wired to the counter output bus on the same clock.

---
 rtl/tiny_count_monitor_if.sv | 26 ++
 rtl/tiny_count_monitor.sv | 106 ++++++++++
 2 files changed

// File: rtl/tiny_count_monitor_if.sv
// Bus between an up/down counter and its monitor: the observed count plus the
// monitor's recovered step/direction/lock/error status.
interface tiny_count_monitor_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic             step;
  logic             dir_up;
  logic             err;
  logic             locked;
  logic [3:0]       err_cnt;
  logic [POS_W-1:0] pos;

  // master: the counter side that drives the count and observes status
  modport master (
    output cnt_in,
    input  step, dir_up, err, locked, err_cnt, pos
  );

  // slave: the monitor itself
  modport slave (
    input  cnt_in,
    output step, dir_up, err, locked, err_cnt, pos
  );
endinterface

// File: rtl/tiny_count_monitor.sv
// Observes a free-running counter value, checks every change is a legal +/-1 move,
// locks after a run of legal steps, flags and counts jumps while locked, tracks net position.
module tiny_count_monitor #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned LOCK_STEPS = 3,
  parameter int unsigned POS_W      = 8
) (
  input logic              clk,
  input logic              rst,
  tiny_count_monitor_if.slave mon
);

  typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

  localparam logic [3:0] LockSteps = 4'(LOCK_STEPS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             prev_valid_q, prev_valid_d;
  logic [3:0]       lock_ctr_q, lock_ctr_d;
  logic             step_q, step_d;
  logic             dir_up_q, dir_up_d;
  logic             err_q, err_d;
  logic [3:0]       err_cnt_q, err_cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_hold;

  // Modular difference makes the 15->0 / 0->15 wrap fall out naturally.
  assign delta   = mon.cnt_in - prev_q;
  assign is_up   = (delta == WIDTH'(1));
  assign is_dn   = (delta == {WIDTH{1'b1}});
  assign is_hold = (delta == '0);

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    lock_ctr_d   = lock_ctr_q;
    step_d       = 1'b0;
    dir_up_d     = dir_up_q;
    err_d        = 1'b0;
    err_cnt_d    = err_cnt_q;
    pos_d        = pos_q;

    if (!prev_valid_q) begin
      prev_d       = mon.cnt_in;
      prev_valid_d = 1'b1;
    end else begin
      prev_d = mon.cnt_in;
      if (is_up || is_dn) begin
        step_d   = 1'b1;
        dir_up_d = is_up;
        pos_d    = is_up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        if (state_q == StUnlocked) begin
          if (lock_ctr_q + 4'd1 == LockSteps) begin
            state_d    = StLocked;
            lock_ctr_d = 4'd0;
          end else begin
            lock_ctr_d = lock_ctr_q + 4'd1;
          end
        end
      end else if (!is_hold) begin
        lock_ctr_d = 4'd0;
        if (state_q == StLocked) begin
          err_d     = 1'b1;
          state_d   = StUnlocked;
          err_cnt_d = (err_cnt_q == 4'hf) ? err_cnt_q : err_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUnlocked;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      lock_ctr_q   <= 4'd0;
      step_q       <= 1'b0;
      dir_up_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 4'd0;
      pos_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      lock_ctr_q   <= lock_ctr_d;
      step_q       <= step_d;
      dir_up_q     <= dir_up_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      pos_q        <= pos_d;
    end
  end

  assign mon.step    = step_q;
  assign mon.dir_up  = dir_up_q;
  assign mon.err     = err_q;
  assign mon.locked  = (state_q == StLocked);
  assign mon.err_cnt = err_cnt_q;
  assign mon.pos     = pos_q;

endmodule
